// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader FSM states, default widths and instruction field bounds
package program_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, WRITE, DONE, ERR} state_t;
    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 15;
    localparam int OP_HI       = 14;
    localparam int OP_LO       = 8;
    localparam int LIT_HI      = 7;
    localparam int LIT_LO      = 0;
endpackage

// File: rtl/program_loader.sv
// program_loader: assembles a byte stream into instruction words and writes them to instruction memory
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_data,
    output logic               cpu_run,
    output logic               busy,
    output logic               error
);
    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0]   data_q, data_d;
    logic                 acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        acc     = in_valid && in_ready;
        unique case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d = HDR;
                cnt_d   = '0;
                addr_d  = '0;
            end
            HDR: if (acc) begin
                cnt_d   = in_data;
                state_d = HI;
            end
            HI: if (acc) begin
                data_d[OP_HI:OP_LO] = in_data[OP_HI-OP_LO:0];
                state_d             = in_data[7] ? ERR : LO;
            end
            LO: if (acc) begin
                data_d[LIT_HI:LIT_LO] = in_data;
                state_d               = WRITE;
            end
            // The address only advances while instructions remain, so a 256-entry load never wraps to 0
            WRITE: begin
                state_d = (cnt_q == 8'd0) ? DONE : HI;
                cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
                addr_d  = (cnt_q == 8'd0) ? addr_q : addr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == HDR) || (state_q == HI) || (state_q == LO);
        im_we    = (state_q == WRITE);
        busy     = in_ready || (state_q == WRITE);
        cpu_run  = (state_q == DONE);
        error    = (state_q == ERR);
        im_addr  = addr_q;
        im_data  = data_q;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench with directed loads, error, stall, reset and ignored-start cases
module tb_program_loader;
    logic        clk, rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, im_we, cpu_run, busy, error;
    logic [7:0]  im_addr;
    logic [14:0] im_data;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int pushed = 0;
    logic [22:0] exp_q[$];

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
        .cpu_run(cpu_run), .busy(busy), .error(error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && im_we) begin
            logic [22:0] e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", im_addr, im_data);
            end else begin
                e = exp_q.pop_front();
                if ({im_addr, im_data} !== e)
                begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             im_addr, im_data, e[22:15], e[14:0]);
                end
            end
            checks++;
            if (in_ready) begin
                errors++;
                $display("FAIL we_ready_overlap: in_ready=1 while im_we=1, expected 0");
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        if (stall) repeat ($urandom_range(0, 3)) begin
            in_valid = 0;
            @(posedge clk); #1;
        end
        in_valid = 1;
        in_data  = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL handshake_timeout: byte %0h not accepted, expected acceptance", b);
    endtask

    task automatic instr(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] addr, input bit stall);
        send(hi, stall);
        exp_q.push_back({addr, hi[6:0], lo});
        pushed++;
        send(lo, stall);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_im_we"},    im_we,    0);
        chk({tag, "_im_addr"},  im_addr,  0);
        chk({tag, "_im_data"},  im_data,  0);
        chk({tag, "_cpu_run"},  cpu_run,  0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_error"},    error,    0);
    endtask

    initial begin
        rst_n = 0; start = 0; in_valid = 0; in_data = 0;
        #3;
        outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // basic two-instruction load, valid held high
        pulse_start();
        chk("hdr_busy", busy, 1);
        send(8'h01, 0);
        instr(8'h0A, 8'h05, 8'd0, 0);
        instr(8'h1F, 8'h80, 8'd1, 0);
        chk("write_cycle_run", cpu_run, 0);
        chk("write_cycle_we", im_we, 1);
        @(posedge clk); #1;
        chk("done_run", cpu_run, 1);
        chk("done_busy", busy, 0);

        // 256-instruction load from DONE
        pulse_start();
        chk("restart_run", cpu_run, 0);
        chk("restart_addr", im_addr, 0);
        send(8'hFF, 0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            instr({1'b0, a[6:0]}, ~a, a, 0);
        end
        @(posedge clk); #1;
        chk("full_run", cpu_run, 1);
        chk("full_addr_nowrap", im_addr, 8'hFF);

        // malformed high byte
        pulse_start();
        send(8'h00, 0);
        send(8'h85, 0);
        chk("err_error", error, 1);
        chk("err_ready", in_ready, 0);
        chk("err_busy", busy, 0);
        chk("err_run", cpu_run, 0);
        in_valid = 1; in_data = 8'h12;
        repeat (3) @(posedge clk);
        #1 in_valid = 0;
        chk("err_sticky", error, 1);
        pulse_start();
        chk("err_cleared", error, 0);
        chk("err_restart_busy", busy, 1);
        send(8'h00, 0);
        instr(8'h01, 8'h02, 8'd0, 0);
        @(posedge clk); #1;
        chk("err_recover_run", cpu_run, 1);

        // random stalls through a 3-instruction load
        pulse_start();
        send(8'h02, 1);
        instr(8'h0A, 8'h05, 8'd0, 1);
        instr(8'h1F, 8'h80, 8'd1, 1);
        instr(8'h7F, 8'hFF, 8'd2, 1);
        @(posedge clk); #1;
        chk("stall_run", cpu_run, 1);

        // reset between HI and LO of instruction 2
        pulse_start();
        send(8'h02, 0);
        instr(8'h11, 8'h22, 8'd0, 0);
        send(8'h33, 0);
        chk("mid_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        outputs_zero("async_reset");
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("post_reset_run", cpu_run, 0);
        pulse_start();
        send(8'h00, 0);
        instr(8'h44, 8'h55, 8'd0, 0);
        @(posedge clk); #1;
        chk("reload_run", cpu_run, 1);

        // start during LO is ignored
        pulse_start();
        send(8'h01, 0);
        send(8'h21, 0);
        pulse_start();
        chk("ign_busy", busy, 1);
        chk("ign_ready", in_ready, 1);
        exp_q.push_back({8'd0, 7'h21, 8'h43});
        pushed++;
        send(8'h43, 0);
        instr(8'h65, 8'h87, 8'd1, 0);
        @(posedge clk); #1;
        chk("ign_run", cpu_run, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("write_count", writes, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction memory address width; 256 entries.
REQ-002 Parameter INSTR_W, default 15: instruction width; opcode is bits 14:8, literal is bits 7:0.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: one-cycle pulse that begins a load session.
REQ-006 Port in_valid, input, 1: a byte is offered on in_data.
REQ-007 Port in_data, input, 8: stream byte.
REQ-008 Port in_ready, output, 1: loader accepts the byte this cycle; transfer occurs when in_valid && in_ready.
REQ-009 Port im_we, output, 1: instruction memory write strobe, one cycle per instruction.
REQ-010 Port im_addr, output, ADDR_W: instruction memory write address.
REQ-011 Port im_data, output, INSTR_W: instruction word to write.
REQ-012 Port cpu_run, output, 1: releases the CPU; held low while loading.
REQ-013 Port busy, output, 1: a session is in progress.
REQ-014 Port error, output, 1: malformed stream detected; sticky until the next start.

Function
REQ-015 FSM states SHALL be IDLE, HDR, HI, LO, WRITE, DONE and ERR.
REQ-016 IDLE: start=1 moves the FSM to HDR, clears error, cpu_run and the address counter, and sets the remaining-count register to 0.
REQ-017 HDR: the accepted byte SHALL be stored as N-1, the instruction count less one; 0xFF means 256 instructions. The FSM then moves to HI.
REQ-018 HI: the accepted byte bits 6:0 SHALL become im_data bits 14:8.
REQ-019 HI: if the accepted byte has bit7=1, the FSM SHALL move to ERR with no write.
REQ-020 LO: the accepted byte SHALL become im_data bits 7:0, and the FSM moves to WRITE.
REQ-021 WRITE: im_we=1 for exactly one cycle, with im_addr and im_data stable during that cycle.
REQ-022 WRITE: on the next edge, im_addr increments by 1; the FSM moves to HI if instructions remain, else to DONE.
REQ-023 Write latency SHALL be one cycle: im_we asserts in the cycle after the LO byte handshake.
REQ-024 in_ready SHALL be 1 only in HDR, HI and LO, and never in the same cycle as im_we.
REQ-025 With in_valid=0 the FSM SHALL hold its state indefinitely; there is no timeout.
REQ-026 The address counter SHALL not wrap within a session: N=256 writes addresses 0..255, then goes to DONE.
REQ-027 DONE: cpu_run=1 and busy=0. start=1 returns the FSM to HDR, drops cpu_run the same edge, and restarts at address 0.
REQ-028 ERR: error=1, cpu_run=0, busy=0, in_ready=0. Only start (to HDR) or reset leaves ERR.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 busy SHALL be 1 in HDR, HI, LO and WRITE, else 0.
REQ-031 im_we SHALL never assert outside WRITE.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and drive in_ready=0, im_we=0, im_addr=0, im_data=0, cpu_run=0, busy=0, error=0, regardless of clk.
REQ-033 Reset mid-session SHALL abandon the session; instructions already written stay in memory, and cpu_run stays 0 until a full session completes.
REQ-034 Deassertion of rst_n SHALL be synchronised by the integrator upstream; the block needs no internal synchroniser.

Structure
REQ-035 Shared package program_loader_pkg SHALL hold the state enumeration, ADDR_W and INSTR_W defaults, and opcode field bounds 14:8 and 7:0.
REQ-036 The block SHALL be a single module with no sub-modules; the FSM, byte assembler and address counter are inline.
REQ-037 The module SHALL drive the instruction memory write port directly; the memory itself is outside this block.

Verification
REQ-038 Reset, then start, then bytes 0x01, 0x0A, 0x05, 0x1F, 0x80 with in_valid held high.
Required: writes 0x0A05 @0, then 0x1F80 @1; cpu_run=1 two cycles after the last byte.
REQ-039 Header 0xFF followed by 512 bytes.
Required: 256 writes at addresses 0..255 with no wrap, then DONE.
REQ-040 Header 0x00, then high byte 0x85.
Required: ERR, error=1, no im_we, in_ready=0; a subsequent start clears error.
REQ-041 in_valid toggled randomly through a 3-instruction load.
Required: identical writes to the stall-free case; im_we never coincides with in_ready.
REQ-042 rst_n=0 asserted between the HI and LO bytes of instruction 2.
Required: all outputs go to zero asynchronously; a new start reloads from address 0.
REQ-043 start pulsed during LO.
Required: ignored; the session completes normally.
